// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, fills IF/ID and parks one word in a skid slot during a stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        jmp,
    input  logic [31:0] jmp_pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_insn_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_insn_q;
    logic        id_valid_q;
    logic        misaligned_q;

    logic [31:0] jmp_tgt;
    logic [31:0] pc_inc;

    assign jmp_tgt = {jmp_pc[31:2], 2'b00};
    assign pc_inc  = pc_q + 32'd4;

    // Request and address are registered, so stall/jmp never reach imem_addr combinationally.
    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_insn_q;
    assign id_valid       = id_valid_q;
    assign misaligned     = misaligned_q;

    always_ff @(posedge clk) begin
        misaligned_q <= 1'b0;
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            skid_pc_q   <= 32'd0;
            skid_insn_q <= NOP_INSN;
            id_pc_q     <= 32'd0;
            id_insn_q   <= NOP_INSN;
            id_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                FETCH: begin
                    if (jmp) begin
                        pc_q         <= jmp_tgt;
                        id_pc_q      <= jmp_pc;
                        id_insn_q    <= NOP_INSN;
                        id_valid_q   <= 1'b0;
                        misaligned_q <= |jmp_pc[1:0];
                        if (imem_valid) begin
                            state_q <= FETCH;
                            addr_q  <= jmp_tgt;
                        end else begin
                            // Old request still in flight: keep its address until it answers.
                            state_q <= FLUSH;
                        end
                    end else if (imem_valid) begin
                        pc_q   <= pc_inc;
                        addr_q <= pc_inc;
                        if (stall) begin
                            skid_pc_q   <= pc_q;
                            skid_insn_q <= imem_rdata;
                            req_q       <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            id_pc_q    <= pc_q;
                            id_insn_q  <= imem_rdata;
                            id_valid_q <= 1'b1;
                        end
                    end else if (!stall) begin
                        id_pc_q    <= pc_q;
                        id_insn_q  <= NOP_INSN;
                        id_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (jmp) begin
                        pc_q         <= jmp_tgt;
                        addr_q       <= jmp_tgt;
                        req_q        <= 1'b1;
                        id_pc_q      <= jmp_pc;
                        id_insn_q    <= NOP_INSN;
                        id_valid_q   <= 1'b0;
                        misaligned_q <= |jmp_pc[1:0];
                        state_q      <= FETCH;
                    end else if (!stall) begin
                        id_pc_q    <= skid_pc_q;
                        id_insn_q  <= skid_insn_q;
                        id_valid_q <= 1'b1;
                        req_q      <= 1'b1;
                        state_q    <= FETCH;
                    end
                end
                FLUSH: begin
                    if (jmp) begin
                        pc_q         <= jmp_tgt;
                        id_pc_q      <= jmp_pc;
                        id_insn_q    <= NOP_INSN;
                        id_valid_q   <= 1'b0;
                        misaligned_q <= |jmp_pc[1:0];
                        // If the stale response lands now, the slot is free for the new target.
                        if (imem_valid) begin
                            addr_q  <= jmp_tgt;
                            state_q <= FETCH;
                        end
                    end else if (imem_valid) begin
                        addr_q  <= pc_q;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
